vx_jal_ret_stack: RTL and testbench

// - Per-warp return-address stack for hardware-interrupt JAL overloading. Sits on ALU commit path between VX_alu_unit and commit.
// - On an overloaded link-writing JAL, substitutes the link value with the return-handler address (RHA) and pushes the true return PC.
// - The interrupt controller pops saved PCs per warp, so nested or repeated scheduler exits are supported (the single-shot scheme is not).

---
 rtl/vx_jal_ret_stack_pkg.sv | 30 +++
 rtl/vx_ret_stack_bank.sv | 60 ++++++
 rtl/vx_jal_ret_stack.sv | 158 +++++++++++++++
 tb/tb_vx_jal_ret_stack.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_jal_ret_stack_pkg.sv
// Shared types and helpers for the per-warp JAL return-address stack.
package vx_jal_ret_stack_pkg;

    localparam int unsigned DEF_NUM_WARPS   = 8;
    localparam int unsigned DEF_NUM_THREADS = 4;
    localparam int unsigned DEF_XLEN        = 32;
    localparam int unsigned DEF_RAS_DEPTH   = 4;
    localparam int unsigned MAX_THREADS     = 32;
    localparam int unsigned LANE_W          = $clog2(MAX_THREADS);
    localparam int unsigned RAS_PTR_W       = $clog2(DEF_RAS_DEPTH + 1);

    typedef logic [RAS_PTR_W-1:0] ras_ptr_t;
    typedef logic [LANE_W-1:0]    lane_t;

    // Index of the lowest active lane; lane 0 when the mask is empty.
    function automatic lane_t lowest_lane(input logic [MAX_THREADS-1:0] tmask);
        lane_t lane;
        logic  found;
        lane  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_THREADS; i++) begin
            if (tmask[i] && !found) begin
                lane  = lane_t'(i);
                found = 1'b1;
            end
        end
        return lane;
    endfunction

endpackage

// File: rtl/vx_ret_stack_bank.sv
// One per-warp LIFO of saved return PCs with depth tracking and the
// simultaneous push/pop overwrite rule.
module vx_ret_stack_bank #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [PTR_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             pop_eff;
    logic             push_ok;

    assign full    = (depth == PTR_W'(DEPTH));
    assign empty   = (depth == '0);
    assign top_idx = depth - PTR_W'(1);
    assign pop_eff = pop & ~empty;
    assign push_ok = push & (~full | pop_eff);
    // A push that coincides with a real pop replaces the entry being popped.
    assign wr_idx  = pop_eff ? top_idx : depth;

    always_comb begin
        pop_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!empty && PTR_W'(k) == top_idx) begin
                pop_data = mem[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (push_ok && !pop_eff) begin
            depth <= depth + PTR_W'(1);
        end else if (pop_eff && !push_ok) begin
            depth <= depth - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (push_ok && PTR_W'(k) == wr_idx) begin
                mem[k] <= push_data;
            end
        end
    end

endmodule

// File: rtl/vx_jal_ret_stack.sv
// ALU-commit-path return-address stack: substitutes the link value of
// overloaded JALs with the return-handler address and saves the true PC per warp.
module vx_jal_ret_stack
    import vx_jal_ret_stack_pkg::*;
#(
    parameter int unsigned ISSUE_CNT  = 4,
    parameter int unsigned WARP_CNT   = DEF_NUM_WARPS,
    parameter int unsigned THREAD_CNT = DEF_NUM_THREADS,
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned RAS_DEPTH  = DEF_RAS_DEPTH,
    parameter int unsigned PAYLOAD_W  = 64,
    parameter int unsigned NW_WIDTH   = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
    parameter int unsigned PTR_W      = $clog2(RAS_DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ISSUE_CNT-1:0]                 in_valid,
    output logic [ISSUE_CNT-1:0]                 in_ready,
    input  logic [ISSUE_CNT*NW_WIDTH-1:0]        in_wid,
    input  logic [ISSUE_CNT*THREAD_CNT-1:0]      in_tmask,
    input  logic [ISSUE_CNT-1:0]                 in_is_link,
    input  logic [ISSUE_CNT*THREAD_CNT*XLEN-1:0] in_data,
    input  logic [ISSUE_CNT*PAYLOAD_W-1:0]       in_payload,
    output logic [ISSUE_CNT-1:0]                 out_valid,
    input  logic [ISSUE_CNT-1:0]                 out_ready,
    output logic [ISSUE_CNT*NW_WIDTH-1:0]        out_wid,
    output logic [ISSUE_CNT*THREAD_CNT-1:0]      out_tmask,
    output logic [ISSUE_CNT*THREAD_CNT*XLEN-1:0] out_data,
    output logic [ISSUE_CNT*PAYLOAD_W-1:0]       out_payload,
    input  logic [WARP_CNT-1:0]                  overload_en,
    input  logic [XLEN-1:0]                      rha,
    input  logic                                 pop_req,
    input  logic [NW_WIDTH-1:0]                  pop_wid,
    output logic                                 pop_rsp_valid,
    output logic [XLEN-1:0]                      pop_rsp_addr,
    output logic                                 pop_rsp_empty,
    output logic [WARP_CNT*PTR_W-1:0]            depth,
    output logic [WARP_CNT-1:0]                  warp_hits,
    output logic [WARP_CNT-1:0]                  overflow
);

    localparam int unsigned SLOT_W = THREAD_CNT * XLEN;

    logic [ISSUE_CNT-1:0] fire;
    logic [ISSUE_CNT-1:0] ovl;
    logic [ISSUE_CNT-1:0] hit;
    logic [ISSUE_CNT-1:0] drop;
    logic [NW_WIDTH-1:0]  slot_wid  [ISSUE_CNT];
    lane_t                slot_lane [ISSUE_CNT];
    logic [XLEN-1:0]      cap       [ISSUE_CNT];

    logic [WARP_CNT-1:0]  push;
    logic [WARP_CNT-1:0]  pop;
    logic [WARP_CNT-1:0]  full;
    logic [WARP_CNT-1:0]  empty;
    logic [WARP_CNT-1:0]  drop_w;
    logic [XLEN-1:0]      push_data [WARP_CNT];
    logic [XLEN-1:0]      pop_data  [WARP_CNT];

    assign in_ready    = out_ready;
    assign out_valid   = in_valid;
    assign out_wid     = in_wid;
    assign out_tmask   = in_tmask;
    assign out_payload = in_payload;

    always_comb begin
        out_data = in_data;
        for (int unsigned i = 0; i < ISSUE_CNT; i++) begin
            slot_wid[i]  = in_wid[i*NW_WIDTH +: NW_WIDTH];
            fire[i]      = in_valid[i] & out_ready[i];
            ovl[i]       = fire[i] & in_is_link[i] & overload_en[slot_wid[i]];
            hit[i]       = ovl[i] & ~full[slot_wid[i]];
            drop[i]      = ovl[i] & full[slot_wid[i]];
            slot_lane[i] = lowest_lane(MAX_THREADS'(in_tmask[i*THREAD_CNT +: THREAD_CNT]));
            cap[i]       = '0;
            for (int unsigned l = 0; l < THREAD_CNT; l++) begin
                if (slot_lane[i] == LANE_W'(l)) begin
                    cap[i] = in_data[(i*THREAD_CNT + l)*XLEN +: XLEN];
                end
            end
            if (hit[i]) begin
                out_data[i*SLOT_W +: SLOT_W] = {THREAD_CNT{rha}};
            end
        end
    end

    // Slots map to disjoint warp sets, so at most one slot drives each warp.
    always_comb begin
        push   = '0;
        pop    = '0;
        drop_w = '0;
        for (int unsigned w = 0; w < WARP_CNT; w++) begin
            push_data[w] = '0;
            pop[w]       = pop_req & (pop_wid == NW_WIDTH'(w));
            for (int unsigned i = 0; i < ISSUE_CNT; i++) begin
                if (slot_wid[i] == NW_WIDTH'(w)) begin
                    if (hit[i]) begin
                        push[w]      = 1'b1;
                        push_data[w] = cap[i];
                    end
                    if (drop[i]) begin
                        drop_w[w] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar w = 0; w < WARP_CNT; w++) begin : g_bank
        vx_ret_stack_bank #(
            .DEPTH (RAS_DEPTH),
            .WIDTH (XLEN),
            .PTR_W (PTR_W)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .push      (push[w]),
            .push_data (push_data[w]),
            .pop       (pop[w]),
            .pop_data  (pop_data[w]),
            .depth     (depth[w*PTR_W +: PTR_W]),
            .full      (full[w]),
            .empty     (empty[w])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_rsp_valid <= 1'b0;
            pop_rsp_addr  <= '0;
            pop_rsp_empty <= 1'b0;
            warp_hits     <= '0;
            overflow      <= '0;
        end else begin
            pop_rsp_valid <= pop_req;
            pop_rsp_addr  <= pop_req ? pop_data[pop_wid] : '0;
            pop_rsp_empty <= pop_req & empty[pop_wid];
            warp_hits     <= warp_hits | push;
            overflow      <= overflow | drop_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ISSUE_CNT; i++) begin
                if (in_valid[i]) begin
                    assert (32'(slot_wid[i]) < WARP_CNT)
                        else $error("slot %0d carries out-of-range warp id %0d", i, slot_wid[i]);
                end
                for (int unsigned j = i + 1; j < ISSUE_CNT; j++) begin
                    assert (!(hit[i] && hit[j] && slot_wid[i] == slot_wid[j]))
                        else $error("slots %0d and %0d push the same warp", i, j);
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_jal_ret_stack.sv
// Directed-vector bench for vx_jal_ret_stack with hand-computed expectations.
module tb_vx_jal_ret_stack;

    localparam int IC = 4;
    localparam int WC = 8;
    localparam int TC = 4;
    localparam int XL = 32;
    localparam int RD = 4;
    localparam int PW = 64;
    localparam int NW = 3;
    localparam int PT = 3;
    localparam int SW = TC * XL;

    logic              clk;
    logic              reset;
    logic [IC-1:0]     in_valid;
    logic [IC-1:0]     in_ready;
    logic [IC*NW-1:0]  in_wid;
    logic [IC*TC-1:0]  in_tmask;
    logic [IC-1:0]     in_is_link;
    logic [IC*SW-1:0]  in_data;
    logic [IC*PW-1:0]  in_payload;
    logic [IC-1:0]     out_valid;
    logic [IC-1:0]     out_ready;
    logic [IC*NW-1:0]  out_wid;
    logic [IC*TC-1:0]  out_tmask;
    logic [IC*SW-1:0]  out_data;
    logic [IC*PW-1:0]  out_payload;
    logic [WC-1:0]     overload_en;
    logic [XL-1:0]     rha;
    logic              pop_req;
    logic [NW-1:0]     pop_wid;
    logic              pop_rsp_valid;
    logic [XL-1:0]     pop_rsp_addr;
    logic              pop_rsp_empty;
    logic [WC*PT-1:0]  depth;
    logic [WC-1:0]     warp_hits;
    logic [WC-1:0]     overflow;

    int vectors     = 0;
    int miscompares = 0;

    vx_jal_ret_stack #(
        .ISSUE_CNT  (IC),
        .WARP_CNT   (WC),
        .THREAD_CNT (TC),
        .XLEN       (XL),
        .RAS_DEPTH  (RD),
        .PAYLOAD_W  (PW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wid        (in_wid),
        .in_tmask      (in_tmask),
        .in_is_link    (in_is_link),
        .in_data       (in_data),
        .in_payload    (in_payload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wid       (out_wid),
        .out_tmask     (out_tmask),
        .out_data      (out_data),
        .out_payload   (out_payload),
        .overload_en   (overload_en),
        .rha           (rha),
        .pop_req       (pop_req),
        .pop_wid       (pop_wid),
        .pop_rsp_valid (pop_rsp_valid),
        .pop_rsp_addr  (pop_rsp_addr),
        .pop_rsp_empty (pop_rsp_empty),
        .depth         (depth),
        .warp_hits     (warp_hits),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PT-1:0] dep(input int w);
        return depth[w*PT +: PT];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        in_valid   = '0;
        in_wid     = '0;
        in_tmask   = '0;
        in_is_link = '0;
        in_data    = '0;
        in_payload = '0;
        pop_req    = 1'b0;
        pop_wid    = '0;
    endtask

    task automatic drive_slot(input int s, input logic [NW-1:0] w, input logic [TC-1:0] tm,
                              input logic [SW-1:0] lanes);
        in_valid[s]            = 1'b1;
        in_wid[s*NW +: NW]     = w;
        in_tmask[s*TC +: TC]   = tm;
        in_is_link[s]          = 1'b1;
        in_data[s*SW +: SW]    = lanes;
        in_payload[s*PW +: PW] = {28'h5A5A000, 4'(s), lanes[31:0]};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++; if (depth !== '0) begin miscompares++; $display("FAIL reset_depth: got %h want 0", depth); end
        vectors++; if (warp_hits !== '0) begin miscompares++; $display("FAIL reset_hits: got %h want 0", warp_hits); end
        vectors++; if (overflow !== '0) begin miscompares++; $display("FAIL reset_overflow: got %h want 0", overflow); end
        vectors++; if ({pop_rsp_valid, pop_rsp_empty, pop_rsp_addr} !== '0) begin
            miscompares++; $display("FAIL reset_rsp: got v=%b e=%b a=%h want all 0", pop_rsp_valid, pop_rsp_empty, pop_rsp_addr);
        end
    endtask

    task automatic test_passthrough;
        logic [SW-1:0] lanes;
        lanes = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h8000_0010};
        overload_en = '0;
        clear_in();
        drive_slot(1, 3'd1, 4'b0001, lanes);
        #1;
        vectors++; if (out_data[SW +: SW] !== lanes) begin miscompares++; $display("FAIL pass_data: got %h want %h", out_data[SW +: SW], lanes); end
        vectors++; if (out_valid !== 4'b0010) begin miscompares++; $display("FAIL pass_valid: got %b want 0010", out_valid); end
        vectors++; if (in_ready !== 4'b1111) begin miscompares++; $display("FAIL pass_ready: got %b want 1111", in_ready); end
        vectors++; if (out_payload[PW +: PW] !== {28'h5A5A000, 4'd1, 32'h8000_0010}) begin
            miscompares++; $display("FAIL pass_payload: got %h want 5a5a000180000010", out_payload[PW +: PW]);
        end
        tick();
        clear_in();
        vectors++; if (dep(1) !== 3'd0) begin miscompares++; $display("FAIL pass_depth: got %0d want 0", dep(1)); end
        vectors++; if (warp_hits !== 8'h00) begin miscompares++; $display("FAIL pass_hits: got %h want 00", warp_hits); end
    endtask

    task automatic test_substitute;
        overload_en = 8'h02;
        rha         = 32'h8000_0400;
        clear_in();
        drive_slot(1, 3'd1, 4'b0100, {32'h8000_0034, 32'h8000_0024, 32'h8000_0014, 32'h8000_0004});
        #1;
        vectors++; if (out_data[SW +: SW] !== {4{32'h8000_0400}}) begin miscompares++; $display("FAIL sub_data: got %h want 4x80000400", out_data[SW +: SW]); end
        vectors++; if (out_wid[NW +: NW] !== 3'd1) begin miscompares++; $display("FAIL sub_wid: got %0d want 1", out_wid[NW +: NW]); end
        tick();
        clear_in();
        vectors++; if (dep(1) !== 3'd1) begin miscompares++; $display("FAIL sub_depth: got %0d want 1", dep(1)); end
        vectors++; if (warp_hits !== 8'h02) begin miscompares++; $display("FAIL sub_hits: got %h want 02", warp_hits); end
        pop_req = 1'b1;
        pop_wid = 3'd1;
        tick();
        clear_in();
        vectors++; if (pop_rsp_valid !== 1'b1 || pop_rsp_empty !== 1'b0) begin
            miscompares++; $display("FAIL sub_pop_flags: got v=%b e=%b want v=1 e=0", pop_rsp_valid, pop_rsp_empty);
        end
        vectors++; if (pop_rsp_addr !== 32'h8000_0024) begin miscompares++; $display("FAIL sub_pop_addr: got %h want 80000024", pop_rsp_addr); end
        vectors++; if (dep(1) !== 3'd0) begin miscompares++; $display("FAIL sub_pop_depth: got %0d want 0", dep(1)); end
        tick();
        vectors++; if (pop_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL sub_rsp_strobe: got %b want 0", pop_rsp_valid); end
    endtask

    task automatic test_overflow;
        logic [SW-1:0] lanes;
        logic [XL-1:0] exp_addr;
        overload_en = 8'h06;
        for (int k = 0; k < 5; k++) begin
            clear_in();
            lanes = {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'h0000_0100 + 32'(k)};
            drive_slot(2, 3'd2, (k == 0) ? 4'b0000 : 4'b0001, lanes);
            #1;
            if (k < 4) begin
                vectors++; if (out_data[2*SW +: SW] !== {4{32'h8000_0400}}) begin
                    miscompares++; $display("FAIL ovf_sub%0d: got %h want 4x80000400", k, out_data[2*SW +: SW]);
                end
            end else begin
                vectors++; if (out_data[2*SW +: SW] !== lanes) begin
                    miscompares++; $display("FAIL ovf_pass: got %h want %h", out_data[2*SW +: SW], lanes);
                end
            end
            tick();
        end
        clear_in();
        vectors++; if (dep(2) !== 3'd4) begin miscompares++; $display("FAIL ovf_depth: got %0d want 4", dep(2)); end
        vectors++; if (overflow !== 8'h04) begin miscompares++; $display("FAIL ovf_flag: got %h want 04", overflow); end
        vectors++; if (warp_hits !== 8'h06) begin miscompares++; $display("FAIL ovf_hits: got %h want 06", warp_hits); end
        for (int k = 0; k < 5; k++) begin
            pop_req  = 1'b1;
            pop_wid  = 3'd2;
            exp_addr = (k < 4) ? 32'h0000_0103 - 32'(k) : 32'h0;
            tick();
            vectors++; if (pop_rsp_valid !== 1'b1 || pop_rsp_addr !== exp_addr || pop_rsp_empty !== (k == 4)) begin
                miscompares++;
                $display("FAIL ovf_pop%0d: got v=%b a=%h e=%b want v=1 a=%h e=%b", k, pop_rsp_valid, pop_rsp_addr,
                         pop_rsp_empty, exp_addr, (k == 4));
            end
        end
        clear_in();
        vectors++; if (dep(2) !== 3'd0) begin miscompares++; $display("FAIL ovf_drained: got %0d want 0", dep(2)); end
    endtask

    task automatic test_backpressure;
        logic [SW-1:0] lanes;
        lanes       = {32'h0000_0333, 32'h0000_0322, 32'h0000_0300, 32'h0000_0311};
        overload_en = 8'h0E;
        out_ready   = 4'b0111;
        clear_in();
        drive_slot(3, 3'd3, 4'b0010, lanes);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (in_ready[3] !== 1'b0 || out_data[3*SW +: SW] !== lanes) begin
                miscompares++; $display("FAIL bp_stall%0d: got rdy=%b data=%h want rdy=0 data=%h", k, in_ready[3], out_data[3*SW +: SW], lanes);
            end
            tick();
        end
        vectors++; if (dep(3) !== 3'd0) begin miscompares++; $display("FAIL bp_nopush: got %0d want 0", dep(3)); end
        out_ready = 4'b1111;
        #1;
        vectors++; if (out_data[3*SW +: SW] !== {4{32'h8000_0400}}) begin
            miscompares++; $display("FAIL bp_sub: got %h want 4x80000400", out_data[3*SW +: SW]);
        end
        tick();
        clear_in();
        vectors++; if (dep(3) !== 3'd1) begin miscompares++; $display("FAIL bp_depth: got %0d want 1", dep(3)); end
        pop_req = 1'b1;
        pop_wid = 3'd3;
        tick();
        clear_in();
        vectors++; if (pop_rsp_addr !== 32'h0000_0300 || dep(3) !== 3'd0) begin
            miscompares++; $display("FAIL bp_pop: got a=%h d=%0d want a=00000300 d=0", pop_rsp_addr, dep(3));
        end
    endtask

    task automatic test_push_pop_same;
        overload_en = 8'h02;
        clear_in();
        drive_slot(1, 3'd1, 4'b0001, {96'h0, 32'h0000_00A0});
        tick();
        clear_in();
        vectors++; if (dep(1) !== 3'd1) begin miscompares++; $display("FAIL pp_setup: got %0d want 1", dep(1)); end
        drive_slot(1, 3'd1, 4'b0001, {96'h0, 32'h0000_00B0});
        pop_req = 1'b1;
        pop_wid = 3'd1;
        #1;
        vectors++; if (out_data[SW +: SW] !== {4{32'h8000_0400}}) begin miscompares++; $display("FAIL pp_sub: got %h want 4x80000400", out_data[SW +: SW]); end
        tick();
        clear_in();
        vectors++; if (pop_rsp_valid !== 1'b1 || pop_rsp_addr !== 32'h0000_00A0 || pop_rsp_empty !== 1'b0 || dep(1) !== 3'd1) begin
            miscompares++; $display("FAIL pp_same: got v=%b a=%h e=%b d=%0d want v=1 a=000000a0 e=0 d=1", pop_rsp_valid, pop_rsp_addr, pop_rsp_empty, dep(1));
        end
        pop_req = 1'b1;
        pop_wid = 3'd1;
        tick();
        clear_in();
        vectors++; if (pop_rsp_addr !== 32'h0000_00B0 || dep(1) !== 3'd0) begin
            miscompares++; $display("FAIL pp_next: got a=%h d=%0d want a=000000b0 d=0", pop_rsp_addr, dep(1));
        end
        drive_slot(1, 3'd1, 4'b0001, {96'h0, 32'h0000_00C0});
        pop_req = 1'b1;
        pop_wid = 3'd1;
        tick();
        clear_in();
        vectors++; if (pop_rsp_valid !== 1'b1 || pop_rsp_empty !== 1'b1 || pop_rsp_addr !== 32'h0 || dep(1) !== 3'd1) begin
            miscompares++; $display("FAIL pp_empty: got v=%b e=%b a=%h d=%0d want v=1 e=1 a=0 d=1", pop_rsp_valid, pop_rsp_empty, pop_rsp_addr, dep(1));
        end
        pop_req = 1'b1;
        pop_wid = 3'd1;
        tick();
        clear_in();
        vectors++; if (pop_rsp_addr !== 32'h0000_00C0 || pop_rsp_empty !== 1'b0 || dep(1) !== 3'd0) begin
            miscompares++; $display("FAIL pp_after_empty: got a=%h e=%b d=%0d want a=000000c0 e=0 d=0", pop_rsp_addr, pop_rsp_empty, dep(1));
        end
    endtask

    task automatic test_back_to_back_reset;
        overload_en = 8'h03;
        clear_in();
        drive_slot(0, 3'd0, 4'b0001, {96'h0, 32'h0000_00D0});
        drive_slot(1, 3'd1, 4'b0001, {96'h0, 32'h0000_00D1});
        tick();
        clear_in();
        vectors++; if (dep(0) !== 3'd1 || dep(1) !== 3'd1) begin
            miscompares++; $display("FAIL b2b_depths: got d0=%0d d1=%0d want 1 1", dep(0), dep(1));
        end
        vectors++; if (warp_hits[1:0] !== 2'b11) begin miscompares++; $display("FAIL b2b_hits: got %b want 11", warp_hits[1:0]); end
        pop_req = 1'b1;
        pop_wid = 3'd0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        clear_in();
        vectors++; if (pop_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_drop: got %b want 0", pop_rsp_valid); end
        vectors++; if (depth !== '0 || warp_hits !== '0 || overflow !== '0) begin
            miscompares++; $display("FAIL rst_clear: got d=%h h=%h o=%h want 0 0 0", depth, warp_hits, overflow);
        end
        tick();
        vectors++; if (pop_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_idle: got %b want 0", pop_rsp_valid); end
    endtask

    initial begin
        reset       = 1'b1;
        out_ready   = '1;
        overload_en = '0;
        rha         = '0;
        clear_in();
        test_reset();
        test_passthrough();
        test_substitute();
        test_overflow();
        test_backpressure();
        test_push_pop_same();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
